alu_share_arbiter: RTL and testbench

- Shares one 32-bit ALU datapath (add/sub/and/or/xor/slt/sltu, zero/sign flags) among N_REQ requesters.
- Each requester issues an operation with a valid/ready handshake. The block arbitrates round-robin, drives the ALU from registered operands, and captures the result and flags.
- The captured result is returned to the winning requester through a per-requester response handshake.
- Sits between the shared ALU instance and the client units (e.g. address generation and branch-compare engines).

---
 rtl/alu_share_pkg.sv | 18 +
 rtl/alu_share_arbiter_rr_pick.sv | 30 +++
 rtl/alu_share_arbiter.sv | 113 +++++++++++
 tb/tb_alu_share_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_pkg.sv
// Shared definitions for the ALU-sharing arbiter: ALU op codes and FSM states.
package alu_share_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_SLT  = 3'd5;
  localparam logic [2:0] OP_SLTU = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index at or after ptr, wrapping.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   valid,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] idx,
  output logic           any
);

  int j;

  // Scan from the farthest offset back to ptr so the closest valid index wins last.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = |valid;
    j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (|(valid & (N'(1) << j))) begin
        grant = N'(1) << j;
        idx   = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one external ALU among N_REQ requesters.
module alu_share_arbiter
  import alu_share_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = 32,
  parameter int IDW   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  input  logic [N_REQ*3-1:0] req_op,
  output logic [N_REQ-1:0]   rsp_valid,
  input  logic [N_REQ-1:0]   rsp_ready,
  output logic [W-1:0]       rsp_res,
  output logic               rsp_zero,
  output logic               rsp_sign,
  output logic [IDW-1:0]     rsp_id,
  output logic               busy,
  output logic [W-1:0]       alu_a,
  output logic [W-1:0]       alu_b,
  output logic [2:0]         alu_control,
  input  logic [W-1:0]       alu_res,
  input  logic               alu_zero,
  input  logic               alu_sign
);

  state_t         state, state_n;
  logic [IDW-1:0] ptr, ptr_next;
  logic [W-1:0]   a_q, b_q, res_q;
  logic [2:0]     op_q;
  logic [IDW-1:0] id_q;
  logic           zero_q, sign_q;

  logic [N_REQ-1:0] pick_grant;
  logic [IDW-1:0]   pick_idx;
  logic             pick_any;
  logic             rsp_done;

  rr_pick #(.N(N_REQ), .IDW(IDW)) u_pick (
    .valid (req_valid),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign rsp_done = rsp_ready[id_q];
  assign ptr_next = (int'(id_q) == N_REQ - 1) ? '0 : id_q + IDW'(1);

  // State register; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state: accept in IDLE, one execute cycle, hold response until accepted.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (pick_any) state_n = EXEC;
      EXEC:    state_n = RESP;
      RESP:    if (rsp_done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Operand latch, result capture and round-robin pointer update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      id_q   <= '0;
      res_q  <= '0;
      zero_q <= 1'b0;
      sign_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (pick_any) begin
          a_q  <= req_a[int'(pick_idx)*W +: W];
          b_q  <= req_b[int'(pick_idx)*W +: W];
          op_q <= req_op[int'(pick_idx)*3 +: 3];
          id_q <= pick_idx;
        end
        EXEC: begin
          res_q  <= alu_res;
          zero_q <= alu_zero;
          sign_q <= alu_sign;
        end
        RESP: if (rsp_done) ptr <= ptr_next;
        default: ;
      endcase
    end
  end

  // req_ready is gated by rst_n so it reads 0 while reset is held.
  assign req_ready   = (state == IDLE && rst_n) ? pick_grant : '0;
  assign rsp_valid   = (state == RESP) ? (N_REQ'(1) << id_q) : '0;
  assign rsp_res     = res_q;
  assign rsp_zero    = zero_q;
  assign rsp_sign    = sign_q;
  assign rsp_id      = id_q;
  assign busy        = (state != IDLE);
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_control = op_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter with a behavioural ALU.
module tb_alu_share_arbiter;
  import alu_share_pkg::*;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*W-1:0] req_a, req_b;
  logic [N*3-1:0] req_op;
  logic [W-1:0]   rsp_res, alu_a, alu_b, alu_res;
  logic           rsp_zero, rsp_sign, busy, alu_zero, alu_sign;
  logic [1:0]     rsp_id;
  logic [2:0]     alu_control;

  int n_checks = 0;
  int n_fail   = 0;

  alu_share_arbiter #(.N_REQ(N), .W(W), .IDW(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_res(rsp_res), .rsp_zero(rsp_zero), .rsp_sign(rsp_sign), .rsp_id(rsp_id),
    .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_res(alu_res), .alu_zero(alu_zero), .alu_sign(alu_sign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU standing in for the shared datapath.
  always_comb begin
    case (alu_control)
      OP_ADD:  alu_res = alu_a + alu_b;
      OP_SUB:  alu_res = alu_a - alu_b;
      OP_AND:  alu_res = alu_a & alu_b;
      OP_OR:   alu_res = alu_a | alu_b;
      OP_XOR:  alu_res = alu_a ^ alu_b;
      OP_SLT:  alu_res = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      OP_SLTU: alu_res = (alu_a < alu_b) ? 32'd1 : 32'd0;
      default: alu_res = 32'd0;
    endcase
    alu_zero = (alu_res == 32'd0);
    alu_sign = alu_res[W-1];
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    req_op[i*3 +: 3] = op;
    req_a[i*W +: W]  = a;
    req_b[i*W +: W]  = b;
    req_valid[i]     = 1'b1;
  endtask

  // Present a request, wait (bounded) for its grant, and leave the DUT in RESP.
  task automatic run_op(input int i, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, output bit ok);
    set_req(i, op, a, b);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (req_ready[i]) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
    end
    tick();
    req_valid[i] = 1'b0;
    tick();
  endtask

  task automatic complete(input int i);
    rsp_ready[i] = 1'b1;
    tick();
    rsp_ready[i] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0; req_op = '0;
    #12;
    n_checks++; if (req_ready !== 4'b0)  begin n_fail++; $display("[TB] FAIL reset_req_ready: got %b want 0000", req_ready); end
    n_checks++; if (rsp_valid !== 4'b0)  begin n_fail++; $display("[TB] FAIL reset_rsp_valid: got %b want 0000", rsp_valid); end
    n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_control !== 3'd0)
                                          begin n_fail++; $display("[TB] FAIL reset_alu: got %h %h %h want 0", alu_a, alu_b, alu_control); end
    n_checks++; if (rsp_res !== 32'd0 || rsp_id !== 2'd0 || rsp_zero !== 1'b0 || rsp_sign !== 1'b0)
                                          begin n_fail++; $display("[TB] FAIL reset_rsp: got %h %h %b %b want 0", rsp_res, rsp_id, rsp_zero, rsp_sign); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    set_req(1, OP_ADD, 32'd5, 32'd7);
    #1;
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("[TB] FAIL single_ready: got %b want 0010", req_ready); end
    n_checks++; if (busy !== 1'b0)         begin n_fail++; $display("[TB] FAIL single_idle_busy: got %b want 0", busy); end
    tick();
    req_valid[1] = 1'b0;
    n_checks++; if (busy !== 1'b1 || rsp_valid !== 4'b0) begin n_fail++; $display("[TB] FAIL single_exec: busy %b rsp_valid %b want 1 0000", busy, rsp_valid); end
    n_checks++; if (alu_a !== 32'd5 || alu_b !== 32'd7 || alu_control !== OP_ADD)
                                          begin n_fail++; $display("[TB] FAIL single_alu_drive: got %h %h %h want 5 7 0", alu_a, alu_b, alu_control); end
    tick();
    n_checks++; if (rsp_valid !== 4'b0010) begin n_fail++; $display("[TB] FAIL single_rsp_valid: got %b want 0010", rsp_valid); end
    n_checks++; if (rsp_res !== 32'd12 || rsp_zero !== 1'b0 || rsp_sign !== 1'b0 || rsp_id !== 2'd1)
                                          begin n_fail++; $display("[TB] FAIL single_rsp: got %h z%b s%b id%0d want c z0 s0 id1", rsp_res, rsp_zero, rsp_sign, rsp_id); end
    complete(1);
    n_checks++; if (busy !== 1'b0 || rsp_valid !== 4'b0) begin n_fail++; $display("[TB] FAIL single_done: busy %b rsp_valid %b want 0 0000", busy, rsp_valid); end
  endtask

  task automatic test_flags();
    bit ok;
    run_op(0, OP_SUB, 32'd3, 32'd3, ok);
    n_checks++; if (!ok) begin n_fail++; $display("[TB] FAIL flags_sub_eq_grant: got no grant want grant"); end
    n_checks++; if (rsp_res !== 32'd0 || rsp_zero !== 1'b1 || rsp_sign !== 1'b0)
                 begin n_fail++; $display("[TB] FAIL flags_sub_eq: got %h z%b s%b want 0 z1 s0", rsp_res, rsp_zero, rsp_sign); end
    complete(0);
    run_op(0, OP_SUB, 32'd2, 32'd5, ok);
    n_checks++; if (!ok) begin n_fail++; $display("[TB] FAIL flags_sub_neg_grant: got no grant want grant"); end
    n_checks++; if (rsp_res !== 32'hFFFF_FFFD || rsp_zero !== 1'b0 || rsp_sign !== 1'b1)
                 begin n_fail++; $display("[TB] FAIL flags_sub_neg: got %h z%b s%b want fffffffd z0 s1", rsp_res, rsp_zero, rsp_sign); end
    complete(0);
    run_op(0, OP_SLT, 32'hFFFF_FFFF, 32'd1, ok);
    n_checks++; if (!ok || rsp_res !== 32'd1) begin n_fail++; $display("[TB] FAIL flags_slt: got ok%b %h want ok1 1", ok, rsp_res); end
    complete(0);
    run_op(0, OP_SLTU, 32'hFFFF_FFFF, 32'd1, ok);
    n_checks++; if (!ok || rsp_res !== 32'd0 || rsp_zero !== 1'b1) begin n_fail++; $display("[TB] FAIL flags_sltu: got ok%b %h z%b want ok1 0 z1", ok, rsp_res, rsp_zero); end
    complete(0);
  endtask

  task automatic test_backpressure();
    bit ok;
    run_op(2, OP_ADD, 32'd10, 32'd20, ok);
    n_checks++; if (!ok) begin n_fail++; $display("[TB] FAIL bp_grant: got no grant want grant"); end
    set_req(0, OP_ADD, 32'd1, 32'd1);
    set_req(1, OP_ADD, 32'd1, 32'd1);
    set_req(3, OP_ADD, 32'd1, 32'd1);
    rsp_ready = 4'b1011;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++; if (rsp_valid !== 4'b0100 || rsp_res !== 32'd30 || rsp_id !== 2'd2)
                   begin n_fail++; $display("[TB] FAIL bp_hold cycle %0d: got %b %h id%0d want 0100 1e id2", c, rsp_valid, rsp_res, rsp_id); end
      n_checks++; if (req_ready !== 4'b0) begin n_fail++; $display("[TB] FAIL bp_req_ready cycle %0d: got %b want 0000", c, req_ready); end
      tick();
    end
    rsp_ready = 4'b0100;
    tick();
    rsp_ready = 4'b0;
    n_checks++; if (rsp_valid !== 4'b0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_complete: got %b busy %b want 0000 0", rsp_valid, busy); end
    n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("[TB] FAIL bp_next_priority: got %b want 1000", req_ready); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_round_robin();
    int e;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    rsp_ready = 4'hF;
    for (int i = 0; i < N; i++) set_req(i, OP_ADD, W'(i), 32'd100);
    #1;
    for (int n = 0; n < 5; n++) begin
      e = n % N;
      n_checks++; if (req_ready !== (4'(1) << e)) begin n_fail++; $display("[TB] FAIL rr_grant %0d: got %b want %b", n, req_ready, 4'(1) << e); end
      tick();
      tick();
      n_checks++; if (rsp_valid !== (4'(1) << e) || rsp_id !== 2'(e) || rsp_res !== 32'(e + 100))
                   begin n_fail++; $display("[TB] FAIL rr_rsp %0d: got %b id%0d %0d want %b id%0d %0d", n, rsp_valid, rsp_id, rsp_res, 4'(1) << e, e, e + 100); end
      tick();
    end
    req_valid = '0;
    rsp_ready = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    set_req(2, OP_ADD, 32'd1, 32'd2);
    tick();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_mid_exec: busy %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || req_ready !== 4'b0 || rsp_valid !== 4'b0)
                 begin n_fail++; $display("[TB] FAIL rst_mid_ctrl: busy %b rdy %b vld %b want 0", busy, req_ready, rsp_valid); end
    n_checks++; if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_control !== 3'd0 || rsp_res !== 32'd0 || rsp_id !== 2'd0 || rsp_zero !== 1'b0 || rsp_sign !== 1'b0)
                 begin n_fail++; $display("[TB] FAIL rst_mid_data: %h %h %h %h %h %b %b want 0", alu_a, alu_b, alu_control, rsp_res, rsp_id, rsp_zero, rsp_sign); end
    req_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++; if (rsp_valid !== 4'b0 || busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mid_silent %0d: got %b busy %b want 0000 0", c, rsp_valid, busy); end
    end
    set_req(0, OP_ADD, 32'd0, 32'd0);
    set_req(3, OP_ADD, 32'd0, 32'd0);
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("[TB] FAIL rst_mid_ptr: got %b want 0001", req_ready); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_op7_regrant();
    bit ok;
    run_op(1, 3'b111, 32'hFFFF_FFFF, 32'd0, ok);
    n_checks++; if (!ok) begin n_fail++; $display("[TB] FAIL op7_grant: got no grant want grant"); end
    n_checks++; if (rsp_res !== 32'd0 || rsp_zero !== 1'b1 || rsp_id !== 2'd1)
                 begin n_fail++; $display("[TB] FAIL op7_rsp: got %h z%b id%0d want 0 z1 id1", rsp_res, rsp_zero, rsp_id); end
    complete(1);
    run_op(1, OP_ADD, 32'd1, 32'd1, ok);
    n_checks++; if (!ok) begin n_fail++; $display("[TB] FAIL regrant: got no grant want grant"); end
    n_checks++; if (rsp_res !== 32'd2 || rsp_zero !== 1'b0 || rsp_valid !== 4'b0010)
                 begin n_fail++; $display("[TB] FAIL regrant_rsp: got %h z%b %b want 2 z0 0010", rsp_res, rsp_zero, rsp_valid); end
    complete(1);
  endtask

  // Run all scenarios in order, then report.
  initial begin
    test_reset();
    test_single();
    test_flags();
    test_backpressure();
    test_round_robin();
    test_reset_mid();
    test_op7_regrant();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
